// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/writeback.
// Optional macro MC_CTRL_TRAP_EN: illegal opcodes lock the sequencer in TRAP and raise o_illegal.
module multicycle_control #(
    parameter int WAIT_MEM = 1,
    parameter int STATE_W  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_instrCode,
    input  logic               i_memReady,
    output logic               o_pcWrite,
    output logic               o_branch,
    output logic               o_branchNe,
    output logic               o_iorD,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_irWrite,
    output logic               o_memToReg,
    output logic               o_regDst,
    output logic               o_regWrite,
    output logic               o_aluSrcA,
    output logic [1:0]         o_aluSrcB,
    output logic [1:0]         o_aluOp,
    output logic               o_extOp,
    output logic [1:0]         o_pcSource,
    output logic               o_instrDone,
`ifdef MC_CTRL_TRAP_EN
    output logic               o_illegal,
`endif
    output logic [STATE_W-1:0] o_state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_ADDI_EXEC = 4'd9;
    localparam logic [3:0] S_ADDI_WB   = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [5:0] opcode_reg;
    logic       mem_done;
    logic       illegal_op;

    // With WAIT_MEM = 0 every memory access is treated as completing immediately.
    assign mem_done = (WAIT_MEM == 0) ? 1'b1 : i_memReady;

    always_comb begin
        illegal_op = 1'b1;
        case (i_instrCode)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: illegal_op = 1'b0;
            default:                        illegal_op = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= S_IDLE;
            opcode_reg <= 6'h00;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_reg <= i_instrCode;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_IDLE:      state_next = S_FETCH;
            S_FETCH:     state_next = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_instrCode)
                    OP_RTYPE:          state_next = S_EXECUTE;
                    OP_ADDI, OP_ADDIU: state_next = S_ADDI_EXEC;
                    OP_LW, OP_SW:      state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:    state_next = S_BRANCH;
                    OP_J:              state_next = S_JUMP;
`ifdef MC_CTRL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = mem_done ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_done ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_next = S_ALU_WB;
            S_ALU_WB:    state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:      state_next = S_TRAP;
`endif
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_pcWrite   = 1'b0;
        o_branch    = 1'b0;
        o_branchNe  = 1'b0;
        o_iorD      = 1'b0;
        o_memRead   = 1'b0;
        o_memWrite  = 1'b0;
        o_irWrite   = 1'b0;
        o_memToReg  = 1'b0;
        o_regDst    = 1'b0;
        o_regWrite  = 1'b0;
        o_aluSrcA   = 1'b0;
        o_aluSrcB   = 2'b00;
        o_aluOp     = 2'b00;
        o_extOp     = 1'b0;
        o_pcSource  = 2'b00;
        o_instrDone = 1'b0;
        case (state_reg)
            S_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = 2'b01;
                o_irWrite = mem_done;
                o_pcWrite = mem_done;
            end
            S_DECODE: begin
                o_aluSrcB = 2'b11;
                o_extOp   = 1'b1;
`ifndef MC_CTRL_TRAP_EN
                // Illegal opcode retires here as a NOP.
                o_instrDone = illegal_op;
`endif
            end
            S_MEM_ADDR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                o_extOp   = 1'b1;
            end
            S_MEM_READ: begin
                o_memRead = 1'b1;
                o_iorD    = 1'b1;
            end
            S_MEM_WB: begin
                o_regWrite  = 1'b1;
                o_memToReg  = 1'b1;
                o_instrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                o_memWrite  = 1'b1;
                o_iorD      = 1'b1;
                o_instrDone = mem_done;
            end
            S_EXECUTE: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
            end
            S_ALU_WB: begin
                o_regWrite  = 1'b1;
                o_regDst    = 1'b1;
                o_instrDone = 1'b1;
            end
            S_ADDI_EXEC: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                o_extOp   = 1'b1;
            end
            S_ADDI_WB: begin
                o_regWrite  = 1'b1;
                o_instrDone = 1'b1;
            end
            S_BRANCH: begin
                o_aluSrcA   = 1'b1;
                o_aluOp     = 2'b01;
                o_pcSource  = 2'b01;
                o_branch    = (opcode_reg == OP_BEQ);
                o_branchNe  = (opcode_reg == OP_BNE);
                o_instrDone = 1'b1;
            end
            S_JUMP: begin
                o_pcSource  = 2'b10;
                o_pcWrite   = 1'b1;
                o_instrDone = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_TRAP_EN
    assign o_illegal = (state_reg == S_TRAP);
`else
    logic unused_illegal;
    assign unused_illegal = illegal_op;
`endif

    assign o_state = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       ctl;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] instr = 6'h00;
    logic       mem_ready = 1'b0;

    logic       pc_write, branch, branch_ne, ior_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
`ifdef MC_CTRL_TRAP_EN
    logic       illegal;
`endif

    ctl_t act;
    assign act = {pc_write, branch, branch_ne, ior_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  ext_op, pc_source, instr_done};

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event check_ev;

    multicycle_control #(.WAIT_MEM(1), .STATE_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_instrCode (instr),
        .i_memReady  (mem_ready),
        .o_pcWrite   (pc_write),
        .o_branch    (branch),
        .o_branchNe  (branch_ne),
        .o_iorD      (ior_d),
        .o_memRead   (mem_read),
        .o_memWrite  (mem_write),
        .o_irWrite   (ir_write),
        .o_memToReg  (mem_to_reg),
        .o_regDst    (reg_dst),
        .o_regWrite  (reg_write),
        .o_aluSrcA   (alu_src_a),
        .o_aluSrcB   (alu_src_b),
        .o_aluOp     (alu_op),
        .o_extOp     (ext_op),
        .o_pcSource  (pc_source),
        .o_instrDone (instr_done),
`ifdef MC_CTRL_TRAP_EN
        .o_illegal   (illegal),
`endif
        .o_state     (state)
    );

    always #5 clk = ~clk;
    always @(negedge clk) -> check_ev;

    // Expected control word for a state, the ready input that cycle and the instruction's opcode.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        ctl_t c;
        logic legal;
        c = '0;
        legal = (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h05) ||
                (op == 6'h08) || (op == 6'h09) || (op == 6'h23) || (op == 6'h2B);
        case (st)
            4'd1: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd2: begin
                c.alu_src_b = 2'b11; c.ext_op = 1'b1;
`ifndef MC_CTRL_TRAP_EN
                c.instr_done = !legal;
`endif
            end
            4'd3: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_op = 1'b1; end
            4'd4: begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
            4'd5: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            4'd6: begin c.mem_write = 1'b1; c.ior_d = 1'b1; c.instr_done = rdy; end
            4'd7: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            4'd8: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            4'd9: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_op = 1'b1; end
            4'd10: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            4'd11: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.instr_done = 1'b1;
                c.branch = (op == 6'h04); c.branch_ne = (op == 6'h05);
            end
            4'd12: begin c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op, input string tag);
        exp_t e;
        e.st  = st;
        e.ctl = exp_ctl(st, rdy, op);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs just after the edge and predict outputs of the state entered at that edge.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st, input string tag);
        @(posedge clk);
        #1;
        rst = r;
        instr = op;
        mem_ready = rdy;
        push(st, rdy, op, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(check_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
                end
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %05h expected %05h (state %0d)", e.tag, act, e.ctl, state);
                end
`ifdef MC_CTRL_TRAP_EN
                checks++;
                if (illegal !== (e.st == 4'd13)) begin
                    errors++;
                    $display("FAIL %s illegal: got %0b expected %0b", e.tag, illegal, (e.st == 4'd13));
                end
`endif
                $display("cycle %s: state %0d ctl %05h", e.tag, state, act);
            end
        end
    end

    initial begin : stimulus
        // Reset held three cycles, released in the third.
        step(1, 6'h00, 1, 0, "rst0");
        step(1, 6'h00, 1, 0, "rst1");
        step(0, 6'h00, 1, 0, "rst_rel");
        // R-type: 1,2,7,8
        step(0, 6'h00, 1, 1, "r_fetch");
        step(0, 6'h00, 1, 2, "r_decode");
        step(0, 6'h00, 1, 7, "r_exec");
        step(0, 6'h00, 1, 8, "r_wb");
        // Fetch stalled 3 cycles, then LW with 2 wait cycles in MEM_READ.
        for (int i = 0; i < 3; i++) step(0, 6'h23, 0, 1, "lw_fetch_wait");
        step(0, 6'h23, 1, 1, "lw_fetch");
        step(0, 6'h23, 1, 2, "lw_decode");
        step(0, 6'h23, 1, 3, "lw_addr");
        for (int i = 0; i < 2; i++) step(0, 6'h23, 0, 4, "lw_read_wait");
        step(0, 6'h23, 1, 4, "lw_read");
        step(0, 6'h23, 1, 5, "lw_wb");
        // SW: 1,2,3,6
        step(0, 6'h2B, 1, 1, "sw_fetch");
        step(0, 6'h2B, 1, 2, "sw_decode");
        step(0, 6'h2B, 1, 3, "sw_addr");
        step(0, 6'h2B, 1, 6, "sw_write");
        // ADDI: 1,2,9,10
        step(0, 6'h08, 1, 1, "addi_fetch");
        step(0, 6'h08, 1, 2, "addi_decode");
        step(0, 6'h08, 1, 9, "addi_exec");
        step(0, 6'h08, 1, 10, "addi_wb");
        // BNE then BEQ
        step(0, 6'h05, 1, 1, "bne_fetch");
        step(0, 6'h05, 1, 2, "bne_decode");
        step(0, 6'h05, 1, 11, "bne_branch");
        step(0, 6'h04, 1, 1, "beq_fetch");
        step(0, 6'h04, 1, 2, "beq_decode");
        step(0, 6'h04, 1, 11, "beq_branch");
        // J: 1,2,12
        step(0, 6'h02, 1, 1, "j_fetch");
        step(0, 6'h02, 1, 2, "j_decode");
        step(0, 6'h02, 1, 12, "j_jump");
        // Illegal opcode 0x3F
        step(0, 6'h3F, 1, 1, "ill_fetch");
        step(0, 6'h3F, 1, 2, "ill_decode");
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) step(0, 6'h3F, i[0], 13, "trap_hold");
        step(1, 6'h3F, 1, 0, "trap_clear");
        step(0, 6'h3F, 1, 0, "trap_rel");
`endif
        // SW stalled in MEM_WRITE, then async reset mid-cycle.
        step(0, 6'h2B, 1, 1, "sw2_fetch");
        step(0, 6'h2B, 1, 2, "sw2_decode");
        step(0, 6'h2B, 1, 3, "sw2_addr");
        step(0, 6'h2B, 0, 6, "sw2_write_wait");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push(0, 1'b0, 6'h2B, "async_rst");
        -> check_ev;
        step(1, 6'h00, 1, 0, "async_hold");
        step(0, 6'h00, 1, 0, "async_rel");
        step(0, 6'h00, 1, 1, "post_fetch");
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
